// File: rtl/puf_response_uart_tx.sv
// 8N1 UART transmitter for a latched PUF response: HEADER, NBYTES data bytes
// (LSB byte first), then the XOR of the data bytes.
module puf_response_uart_tx #(
  parameter int          CLKS_PER_BIT = 434,
  parameter int          NBYTES       = 5,
  parameter logic [7:0]  HEADER       = 8'hA5
) (
  input  logic                  Clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [8*NBYTES-1:0]   response,
  output logic                  tx,
  output logic                  busy,
  output logic                  done
);
  localparam int BCW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIW = $clog2(NBYTES + 2);
  localparam logic [BCW-1:0] BAUD_LAST = BCW'(CLKS_PER_BIT - 1);
  localparam logic [BIW-1:0] IDX_LAST  = BIW'(NBYTES + 1);
  localparam logic [BIW-1:0] IDX_DATA  = BIW'(NBYTES);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                state_q, state_d;
  logic [BCW-1:0]        baud_q, baud_d;
  logic [2:0]            bit_q, bit_d;
  logic [BIW-1:0]        idx_q, idx_d;
  logic [7:0]            byte_q, byte_d;
  logic [7:0]            chk_q, chk_d;
  logic [8*NBYTES-1:0]   shreg_q, shreg_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic [7:0]            chk_in;
  logic [2:0]            bit_nxt;
  logic                  baud_end;

  always_comb begin
    chk_in = 8'h00;
    for (int i = 0; i < NBYTES; i++) chk_in = chk_in ^ response[8*i +: 8];
  end

  assign bit_nxt  = bit_q + 3'd1;
  assign baud_end = (baud_q == BAUD_LAST);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    idx_d   = idx_q;
    byte_d  = byte_q;
    chk_d   = chk_q;
    shreg_d = shreg_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    // tx_d is the line level for the cycle after this edge, so each branch
    // sets it from the state being entered.
    unique case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        baud_d = '0;
        if (start) begin
          state_d = START;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
          byte_d  = HEADER;
          idx_d   = '0;
          shreg_d = response;
          chk_d   = chk_in;
        end
      end
      START: begin
        tx_d   = 1'b0;
        baud_d = baud_q + 1'b1;
        if (baud_end) begin
          baud_d  = '0;
          state_d = DATA;
          bit_d   = 3'd0;
          tx_d    = byte_q[0];
        end
      end
      DATA: begin
        tx_d   = byte_q[bit_q];
        baud_d = baud_q + 1'b1;
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d = bit_nxt;
            tx_d  = byte_q[bit_nxt];
          end
        end
      end
      STOP: begin
        tx_d   = 1'b1;
        baud_d = baud_q + 1'b1;
        if (baud_end) begin
          baud_d = '0;
          if (idx_q < IDX_LAST) begin
            idx_d   = idx_q + 1'b1;
            state_d = START;
            tx_d    = 1'b0;
            if (idx_q < IDX_DATA) begin
              byte_d  = shreg_q[7:0];
              shreg_d = shreg_q >> 8;
            end else begin
              byte_d  = chk_q;
            end
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      idx_q   <= '0;
      byte_q  <= '0;
      chk_q   <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      idx_q   <= idx_d;
      byte_q  <= byte_d;
      chk_q   <= chk_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;
  assign done = done_q;
endmodule

// File: tb/tb_puf_response_uart_tx.sv
// Directed bench: a CLKS_PER_BIT=4 instance for framing, latching, back-to-back
// and abort cases, and a CLKS_PER_BIT=2 instance for the minimum baud count.
module tb_puf_response_uart_tx;
  logic        clk = 1'b0;
  logic        reset;
  logic        start4, start2;
  logic [39:0] response4, response2;
  logic        tx4, busy4, done4;
  logic        tx2, busy2, done2;
  int          n_assert = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  puf_response_uart_tx #(.CLKS_PER_BIT(4), .NBYTES(5), .HEADER(8'hA5)) dut4 (
    .Clk(clk), .reset(reset), .start(start4), .response(response4),
    .tx(tx4), .busy(busy4), .done(done4));

  puf_response_uart_tx #(.CLKS_PER_BIT(2), .NBYTES(5), .HEADER(8'hA5)) dut2 (
    .Clk(clk), .reset(reset), .start(start2), .response(response2),
    .tx(tx2), .busy(busy2), .done(done2));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulse start so it is accepted at the next rising edge; returns 1 ns after it.
  task automatic go(input bit sel);
    @(negedge clk);
    if (sel) start2 = 1'b1; else start4 = 1'b1;
    @(posedge clk);
    #1;
    start2 = 1'b0;
    start4 = 1'b0;
  endtask

  // Cycle k is the k-th negedge after the acceptance edge. Decodes 70 bit
  // periods, checks every sample within a bit agrees and busy stays high.
  task automatic capture(input bit sel, input int cpb, input int poke_k, input bit chain,
                         output logic [55:0] fr, output int done_k, output int errs);
    logic t, b, d, cur;
    int   bi, ph, pos, by;
    fr = '0; done_k = 0; errs = 0; cur = 1'b0;
    for (int k = 1; k <= 70*cpb + 10 && done_k == 0; k++) begin
      @(negedge clk);
      t = sel ? tx2 : tx4;
      b = sel ? busy2 : busy4;
      d = sel ? done2 : done4;
      if (d) begin
        done_k = k;
        if (b || t !== 1'b1) errs++;
        if (chain) begin
          if (sel) start2 = 1'b1; else start4 = 1'b1;
        end
      end else if (k <= 70*cpb) begin
        bi = (k-1) / cpb;
        ph = (k-1) % cpb;
        if (b !== 1'b1) errs++;
        if (ph == 0) cur = t;
        else if (t !== cur) errs++;
        if (ph == cpb-1) begin
          pos = bi % 10;
          by  = bi / 10;
          if (pos == 0) begin
            if (cur !== 1'b0) errs++;
          end else if (pos == 9) begin
            if (cur !== 1'b1) errs++;
          end else fr[by*8 + pos - 1] = cur;
        end
      end else errs++;
      if (k == poke_k) begin start4 = 1'b1; response4 = 40'h0; end
      if (k == poke_k + 1) start4 = 1'b0;
    end
  endtask

  logic [55:0] fr;
  int          dk, er, cnt;

  initial begin
    reset = 1'b0; start4 = 1'b0; start2 = 1'b0;
    response4 = '0; response2 = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("reset_tx4",   tx4,   1'b1);
    chk("reset_busy4", busy4, 1'b0);
    chk("reset_done4", done4, 1'b0);
    chk("reset_tx2",   tx2,   1'b1);
    chk("reset_busy2", busy2, 1'b0);
    chk("reset_done2", done2, 1'b0);

    // Basic frame, all data bytes 5A
    response4 = 40'h5A5A5A5A5A;
    go(0);
    capture(0, 4, 0, 0, fr, dk, er);
    chk("f1_bytes", fr, 56'h5A5A5A5A5A5AA5);
    chk("f1_done_cycle", dk, 281);
    chk("f1_framing", er, 0);
    @(negedge clk);
    chk("f1_done_one_cycle", done4, 1'b0);

    // Mixed bytes; first start bit visible one cycle after acceptance
    response4 = 40'hA5A5FFFFFF;
    go(0);
    chk("f2_first_start_tx", tx4, 1'b0);
    chk("f2_first_busy", busy4, 1'b1);
    capture(0, 4, 0, 0, fr, dk, er);
    chk("f2_bytes", fr, 56'hFFA5A5FFFFFFA5);
    chk("f2_done_cycle", dk, 281);
    chk("f2_framing", er, 0);

    // start while busy plus response change during byte 3: frame unaffected
    response4 = 40'h0123456789;
    go(0);
    capture(0, 4, 125, 0, fr, dk, er);
    chk("f3_bytes", fr, 56'h890123456789A5);
    chk("f3_done_cycle", dk, 281);
    chk("f3_framing", er, 0);
    cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (tx4 !== 1'b1 || busy4 !== 1'b0 || done4 !== 1'b0) cnt++;
    end
    chk("f3_no_second_frame", cnt, 0);

    // start in the done cycle chains a second frame
    response4 = 40'h00000000FF;
    go(0);
    response4 = 40'h1122334455;
    capture(0, 4, 0, 1, fr, dk, er);
    chk("f4a_bytes", fr, 56'hFF00000000FFA5);
    chk("f4a_done_cycle", dk, 281);
    chk("f4a_framing", er, 0);
    @(posedge clk);
    #1 start4 = 1'b0;
    capture(0, 4, 0, 0, fr, dk, er);
    chk("f4b_bytes", fr, 56'h111122334455A5);
    chk("f4b_done_cycle", dk, 281);
    chk("f4b_framing", er, 0);

    // Reset pulse during a data bit of byte 2 (tx low there)
    response4 = 40'hC3C3C3C3C3;
    go(0);
    repeat (93) @(negedge clk);
    chk("abort_pre_tx", tx4, 1'b0);
    reset = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("abort_tx",   tx4,   1'b1);
    chk("abort_busy", busy4, 1'b0);
    chk("abort_done", done4, 1'b0);
    cnt = 0;
    repeat (300) begin
      @(negedge clk);
      if (done4 !== 1'b0 || tx4 !== 1'b1) cnt++;
    end
    chk("abort_no_done", cnt, 0);
    response4 = 40'h0000000001;
    go(0);
    capture(0, 4, 0, 0, fr, dk, er);
    chk("f5_bytes", fr, 56'h010000000001A5);
    chk("f5_done_cycle", dk, 281);
    chk("f5_framing", er, 0);

    // Minimum baud count
    response2 = 40'hDEADBEEF42;
    go(1);
    capture(1, 2, 0, 0, fr, dk, er);
    chk("f6_bytes", fr, 56'h60DEADBEEF42A5);
    chk("f6_done_cycle", dk, 141);
    chk("f6_framing", er, 0);
    @(negedge clk);
    chk("f6_idle_tx", tx2, 1'b1);
    chk("f6_idle_busy", busy2, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
